// File: rtl/apb_master_bridge_pkg.sv
// apb_master_bridge shared types: FSM states, default widths, direction codes.
package apb_master_bridge_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;

  localparam logic APB_READ  = 1'b0;
  localparam logic APB_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB requester bus for apb_master_bridge.
interface apb_master_bridge_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// ACCESS wait-state counter; expired_o flags the last allowed wait cycle.
module apb_master_bridge_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = enable_i &&
                     (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: valid/ready command in, one-cycle response out.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = AW_DEF,
  parameter int DATA_BUS_WIDTH    = DW_DEF,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input logic pclk,
  input logic reset,
  apb_master_bridge_if.master bus
);

  localparam int AW = ADDRESS_BUS_WIDTH;
  localparam int DW = DATA_BUS_WIDTH;

  state_e        state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic pready_ok, slverr_ok;
  logic tmr_clr, tmr_en, tmr_exp;

  // Only a definite 1 counts; x/z on the bus reads as wait / no error.
  assign pready_ok = (bus.pready === 1'b1);
  assign slverr_ok = (bus.pslverr === 1'b1);

`ifdef APB_TIMEOUT_EN
  apb_master_bridge_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (pclk),
    .rst       (reset),
    .clear_i   (tmr_clr),
    .enable_i  (tmr_en),
    .expired_o (tmr_exp)
  );
`else
  logic unused_timer;
  assign unused_timer = tmr_clr ^ tmr_en ^
                        (TIMEOUT_CYCLES >= 1);
  assign tmr_exp = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          pwdata_d    = bus.cmd_wdata;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        tmr_clr   = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        tmr_en = !pready_ok;
        if (pready_ok || tmr_exp) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pready_ok ? slverr_ok : 1'b1;
          rsp_rdata_d = '0;
          if (pready_ok && !slverr_ok &&
              pwrite_q == APB_READ)
            rsp_rdata_d = bus.prdata;
          state_d = RESP;
        end
      end
      RESP: begin
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: vector table plus reset/timeout sequences.
module tb_apb_master_bridge;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic pclk;
  logic reset;

  int n_vec  = 0;
  int n_fail = 0;

  apb_master_bridge_if #(.AW(AW), .DW(DW)) bus ();

  apb_master_bridge #(
    .ADDRESS_BUS_WIDTH (AW),
    .DATA_BUS_WIDTH    (DW),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    int            mode;
    logic [DW-1:0] rd;
    logic          err;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, " idle_ready"}, 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = v.wr ? 'x : v.rd;
    step();
    chk({t, " setup_psel"}, 32'(bus.psel), 1);
    chk({t, " setup_pen"}, 32'(bus.penable), 0);
    chk({t, " setup_rdy"}, 32'(bus.cmd_ready), 0);
    chk({t, " paddr"}, 32'(bus.paddr), 32'(v.addr));
    chk({t, " pwrite"}, 32'(bus.pwrite), 32'(v.wr));
    chk({t, " pwdata"}, bus.pwdata, v.wdata);
    // garbage on the command port while busy
    bus.cmd_write = ~v.wr;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    step();
    chk({t, " acc_psel"}, 32'(bus.psel), 1);
    chk({t, " acc_pen"}, 32'(bus.penable), 1);
    for (int w = 0; w < v.waits; w++) begin
      if (v.mode == 0)
        bus.pready = 1'b0;
      else if (w % 2 == 0)
        bus.pready = 1'bz;
      else
        bus.pready = 1'bx;
      bus.pslverr = 1'b1;
      step();
      chk({t, " wait_sel"},
          32'({bus.psel, bus.penable}), 3);
      chk({t, " wait_addr"}, 32'(bus.paddr), 32'(v.addr));
      chk({t, " wait_wdata"}, bus.pwdata, v.wdata);
      chk({t, " wait_rv"}, 32'(bus.rsp_valid), 0);
    end
    bus.pready    = 1'b1;
    bus.pslverr   = v.err;
    bus.cmd_valid = 1'b0;
    step();
    chk({t, " rsp_valid"}, 32'(bus.rsp_valid), 1);
    chk({t, " rsp_sel"},
        32'({bus.psel, bus.penable}), 0);
    chk({t, " rsp_rdata"}, bus.rsp_rdata, v.exp_rd);
    chk({t, " rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    chk({t, " rsp_rdy"}, 32'(bus.cmd_ready), 0);
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    step();
    chk({t, " post_rv"}, 32'(bus.rsp_valid), 0);
    chk({t, " post_rdy"}, 32'(bus.cmd_ready), 1);
    chk({t, " hold_rdata"}, bus.rsp_rdata, v.exp_rd);
    chk({t, " hold_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
  endtask

  initial begin
    int bad;
    tbl[0] = '{1'b0, 16'h0000, 32'h0, 0, 0,
               32'hAABBCCDD, 1'b0, 32'hAABBCCDD, 1'b0};
    tbl[1] = '{1'b1, 16'h0004, 32'h12345678, 3, 0,
               32'h0, 1'b0, 32'h0, 1'b0};
    tbl[2] = '{1'b0, 16'h0010, 32'h0, 1, 0,
               32'hDEADBEEF, 1'b1, 32'h0, 1'b1};
    tbl[3] = '{1'b0, 16'h0020, 32'h0, 2, 1,
               32'h5A5A1234, 1'b0, 32'h5A5A1234, 1'b0};
    tbl[4] = '{1'b1, 16'hFFFC, 32'hFFFFFFFF, 0, 0,
               32'h0, 1'b1, 32'h0, 1'b1};
    tbl[5] = '{1'b0, 16'hFFFF, 32'h0, 0, 0,
               32'h00000001, 1'b0, 32'h00000001, 1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    bus.pslverr   = 1'b0;
    reset = 1'b1;
    step();
    step();
    chk("rst cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst psel", 32'(bus.psel), 0);
    chk("rst penable", 32'(bus.penable), 0);
    chk("rst pwrite", 32'(bus.pwrite), 0);
    chk("rst paddr", 32'(bus.paddr), 0);
    chk("rst pwdata", bus.pwdata, 0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst rsp_rdata", bus.rsp_rdata, 0);
    chk("rst rsp_err", 32'(bus.rsp_err), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++)
      run_vec(tbl[i], i);

    // reset while in ACCESS drops the transfer
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 16'h0040;
    bus.prdata    = 32'hCAFEF00D;
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("mid acc_pen", 32'(bus.penable), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid psel", 32'(bus.psel), 0);
    chk("mid penable", 32'(bus.penable), 0);
    chk("mid cmd_ready", 32'(bus.cmd_ready), 1);
    chk("mid rsp_valid", 32'(bus.rsp_valid), 0);
    bus.pready = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0)
        bad++;
    end
    chk("mid no_rsp", 32'(bad), 0);
    bus.pready = 1'b0;

    // completer never ready
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 16'h0080;
    bus.prdata    = 32'h11112222;
    step();
    bus.cmd_valid = 1'b0;
    step();
`ifdef APB_TIMEOUT_EN
    step();
    step();
    step();
    chk("to before_psel", 32'(bus.psel), 1);
    chk("to before_rv", 32'(bus.rsp_valid), 0);
    step();
    chk("to psel", 32'(bus.psel), 0);
    chk("to rsp_valid", 32'(bus.rsp_valid), 1);
    chk("to rsp_err", 32'(bus.rsp_err), 1);
    chk("to rsp_rdata", bus.rsp_rdata, 0);
    step();
    chk("to post_rdy", 32'(bus.cmd_ready), 1);
`else
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (bus.psel !== 1'b1 || bus.penable !== 1'b1 ||
          bus.rsp_valid !== 1'b0)
        bad++;
    end
    chk("pending_1000", 32'(bad), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("pending rst_rdy", 32'(bus.cmd_ready), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end

endmodule
